// File: rtl/booth_r4_seq_mult_if.sv
// rtl/booth_r4_seq_mult_if.sv - start/done handshake and operand/product bundle for booth_r4_seq_mult
interface booth_r4_seq_mult_if #(
    parameter int N = 8
) ();
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic [2*N-1:0]   product;
    logic             busy;
    logic             done;

    modport master (
        output start, multiplicand, multiplier,
        input  product, busy, done
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, busy, done
    );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - iterative signed radix-4 Booth multiplier, two multiplier bits per clock
module booth_r4_seq_mult #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    booth_r4_seq_mult_if.slave    bus
);
    localparam int CW = $clog2(N / 2 + 1);
    localparam int SW = 2 * N + 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]     state_q,   state_d;
    logic [N+1:0]   m_q,       m_d;
    logic [N+1:0]   a_q,       a_d;
    logic [N-1:0]   q_q,       q_d;
    logic           qm1_q,     qm1_d;
    logic [CW-1:0]  cnt_q,     cnt_d;
    logic [2*N-1:0] product_q, product_d;
    logic           busy_q,    busy_d;
    logic           done_q,    done_d;

    logic [N+1:0]   addend;
    logic [N+1:0]   sum;
    logic [N+1:0]   m2;
    logic signed [SW-1:0] sh_src;
    logic signed [SW-1:0] shifted;

    always_comb begin
        m2 = {m_q[N:0], 1'b0};
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_q;
            3'b011:         addend = m2;
            3'b100:         addend = ~m2 + 1'b1;
            3'b101, 3'b110: addend = ~m_q + 1'b1;
            default:        addend = '0;
        endcase
        sum     = a_q + addend;
        sh_src  = $signed({sum, q_q, qm1_q});
        shifted = sh_src >>> 2;
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    m_d     = {{2{bus.multiplicand[N-1]}}, bus.multiplicand};
                    q_d     = bus.multiplier;
                    qm1_d   = 1'b0;
                    a_d     = '0;
                    cnt_d   = CW'(N / 2);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = shifted[SW-1:N+1];
                q_d   = shifted[N:1];
                qm1_d = shifted[0];
                cnt_d = cnt_q - CW'(1);
                // Final iteration: the low 2N bits of the shifted {A,Q} are the product.
                if (cnt_q == CW'(1)) begin
                    product_d = shifted[2*N:1];
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.product = product_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: doc/booth_r4_seq_mult.md
# booth_r4_seq_mult

Iterative signed radix-4 Booth multiplier. It retires two multiplier bits per clock using the registered Booth encode/add/shift datapath built on the team's clearable D flip-flop stage. A single start/done handshake drives it. It sits between the operand source and the result consumer, and presents a held, registered 2N-bit product.

## Interface
Parameters:
- N, 8, operand width in bits; must be even and ≥ 4.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-high reset; one clock domain only.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  N  signed two's-complement M; sampled with start.
- multiplier  input  N  signed two's-complement Q; sampled with start.
- product  output  2N  signed M×Q; registered, held until the next result is written.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; product is valid from this cycle onward.

## Operation
- State machine: IDLE, RUN, DONE.
  - IDLE → RUN when start=1 at a clock edge.
  - RUN → DONE after the N/2-th iteration.
  - DONE → IDLE unconditionally.
- On accept, the block:
  - latches M into an (N+2)-bit sign-extended register;
  - loads Q into the low shift register, with an appended bit q₋₁=0;
  - clears the (N+2)-bit high accumulator A;
  - sets the iteration counter to N/2.
- Each RUN cycle decodes the triplet {Q[1], Q[0], q₋₁}:
  - 000 or 111 → +0
  - 001 or 010 → +M
  - 011 → +2M
  - 100 → −2M
  - 101 or 110 → −M
- Arithmetic per RUN cycle:
  - A ← A + addend, computed modulo 2^(N+2). No overflow is possible at this width.
  - Then the concatenation {A, Q, q₋₁} is shifted right arithmetically by 2; A's sign bit is replicated.
  - The counter decrements.
- On the RUN→DONE edge:
  - product ← {A[N−1:0], Q}, i.e. the low 2N bits of the shifted result;
  - done ← 1.
- Operand registers are internal. Changes on the input pins after acceptance have no effect on the result.
- start outside IDLE (RUN or DONE) is ignored and not queued.
- Reset values: product=0, busy=0, done=0, state=IDLE, internal registers=0.
- clr asserted mid-operation:
  - the block immediately returns to IDLE and all outputs go to their reset values;
  - the partial result is discarded;
  - no done pulse follows release.

## Timing
- Edge t0: start sampled in IDLE. busy=1 after t0.
- Edges t1..t(N/2): one Booth iteration each.
- At t(N/2) the state becomes DONE: done=1 and the new product is visible for exactly one cycle of done.
- Edge t(N/2+1): state=IDLE, busy=0, done=0. The product value persists.
- Latency from start to done: N/2 clocks (4 for N=8).
- Initiation interval: N/2+2 clocks. The earliest new start is accepted at edge t(N/2+1)+1, the first edge seen in IDLE.
- clr is asynchronous on assertion; outputs change without a clock edge.
- Release of clr is assumed synchronous to clk by the upstream reset synchroniser. The first start is accepted on the first edge with clr=0.
- Simultaneous clr and start: clr wins and start is lost.

## Test plan
- N=8, M=3, Q=5, start pulse → busy rises after t0, done at t4, product=0x000F. Product holds 0x000F after done falls.
- M=−7 (0xF9), Q=6 → product=0xFFD6 (−42). M=6, Q=−7 → same value.
- Corner values:
  - M=Q=−128 (0x80) → product=0x4000.
  - M=−128, Q=127 → product=0xC080.
  - M=0, Q=−1 → product=0x0000.
- Start held high continuously with M/Q changing every cycle:
  - exactly one operation per N/2+2 cycles;
  - each product matches the operands present at its accepting edge;
  - starts pulsed during RUN/DONE produce no extra done.
- clr pulse between t1 and t3:
  - busy, done and product go to 0 asynchronously with no done afterwards;
  - a subsequent start with M=2, Q=−3 yields product=0xFFFA with normal latency.
- Randomised sweep of all 65,536 operand pairs, compared against a signed reference model: zero mismatches; done exactly once per accepted start.
